l1_threshold_servo: RTL and testbench

//  Closed-loop per-beam L1 threshold sequencer. On each scaler-period-complete pulse it reads every

---
 rtl/l1_servo_pkg.sv | 24 ++
 rtl/l1_servo_wbm.sv | 78 +++++++
 rtl/l1_threshold_servo.sv | 235 +++++++++++++++++++++++
 tb/tb_l1_threshold_servo.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l1_servo_pkg.sv
// rtl/l1_servo_pkg.sv - address map, state encodings and helpers shared by the L1 threshold servo
package l1_servo_pkg;

  localparam logic [14:0] SCALER_BASE = 15'h0400;
  localparam logic [14:0] THRESH_BASE = 15'h0800;
  localparam logic [14:0] APPLY_ADDR  = 15'h0000;
  localparam logic [31:0] APPLY_WORD  = 32'h1;

  typedef logic [2:0] servo_state_t;

  localparam servo_state_t S_IDLE      = 3'd0;
  localparam servo_state_t S_RD_SCALER = 3'd1;
  localparam servo_state_t S_CALC      = 3'd2;
  localparam servo_state_t S_WR_THRESH = 3'd3;
  localparam servo_state_t S_RB_THRESH = 3'd4;
  localparam servo_state_t S_WR_APPLY  = 3'd5;
  localparam servo_state_t S_DONE      = 3'd6;

  // Per-beam registers sit on a 4-byte stride above their block base.
  function automatic logic [14:0] beam_addr(input logic [14:0] base, input logic [5:0] beam);
    return base + {7'd0, beam, 2'b00};
  endfunction

endpackage

// File: rtl/l1_servo_wbm.sv
// rtl/l1_servo_wbm.sv - single-transfer classic Wishbone master with per-transfer timeout
module l1_servo_wbm
  import l1_servo_pkg::*;
#(
  parameter int WB_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [14:0] adr,
  input  logic [31:0] wdat,
  output logic        done,
  output logic        err,
  output logic [31:0] rdat,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [14:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic        wbm_rty_i
);

  localparam int TW = $clog2(WB_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(WB_TIMEOUT - 1);

  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      wbm_sel_o <= '0;
      tmo_cnt   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      rdat      <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (!wbm_cyc_o) begin
        if (req) begin
          wbm_cyc_o <= 1'b1;
          wbm_stb_o <= 1'b1;
          wbm_we_o  <= we;
          wbm_adr_o <= adr;
          wbm_dat_o <= we ? wdat : '0;
          wbm_sel_o <= 4'hF;
          tmo_cnt   <= '0;
        end
      end else if (wbm_err_i || wbm_rty_i || (!wbm_ack_i && tmo_cnt == TMO_LAST)) begin
        // Retry is not honoured: it ends the transfer exactly like an error.
        wbm_cyc_o <= 1'b0;
        wbm_stb_o <= 1'b0;
        wbm_we_o  <= 1'b0;
        wbm_sel_o <= '0;
        err       <= 1'b1;
      end else if (wbm_ack_i) begin
        wbm_cyc_o <= 1'b0;
        wbm_stb_o <= 1'b0;
        wbm_we_o  <= 1'b0;
        wbm_sel_o <= '0;
        done      <= 1'b1;
        rdat      <= wbm_dat_i;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/l1_threshold_servo.sv
// rtl/l1_threshold_servo.sv - per-beam L1 threshold servo sweeping scalers/thresholds over Wishbone
// Optional threshold readback check: define THRESH_SERVO_READBACK_EN.
module l1_threshold_servo
  import l1_servo_pkg::*;
#(
  parameter int                     NBEAMS      = 2,
  parameter int                     THRESH_BITS = 18,
  parameter logic [THRESH_BITS-1:0] THRESH_INIT = 18'd4000,
  parameter logic [THRESH_BITS-1:0] THRESH_MIN  = 18'd1000,
  parameter logic [THRESH_BITS-1:0] THRESH_MAX  = 18'h3FFFF,
  parameter int                     WB_TIMEOUT  = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        enable_i,
  input  logic        count_done_i,
  input  logic [31:0] target_i,
  input  logic [15:0] deadband_i,
  input  logic [7:0]  step_i,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [14:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic        wbm_rty_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [1:0]  err_o
);

  localparam int BW    = (NBEAMS > 1) ? $clog2(NBEAMS) : 1;
  localparam int NSLOT = 1 << BW;
  localparam int TB1   = THRESH_BITS + 1;
  localparam logic [BW-1:0] LAST_BEAM = BW'(NBEAMS - 1);

  servo_state_t           state;
  logic [BW-1:0]          beam;
  logic [THRESH_BITS-1:0] shadow [0:NSLOT-1];
  logic                   pending;
  logic [1:0]             err_r;
  logic                   req;

  logic        req_we;
  logic [14:0] req_adr;
  logic [31:0] req_wdat;
  logic        wb_done;
  logic        wb_err;
  logic [31:0] wb_rdat;

  logic [THRESH_BITS-1:0] cur;
  logic [THRESH_BITS-1:0] calc_next;
  logic [THRESH_BITS:0]   up_sum;
  logic [THRESH_BITS:0]   dn_limit;
  logic [32:0]            cnt_ext;
  logic [32:0]            hi;
  logic [32:0]            lo;

  assign busy_o = (state != S_IDLE);
  assign done_o = (state == S_DONE);
  assign err_o  = err_r;

  always_comb begin
    req_we   = 1'b0;
    req_adr  = beam_addr(SCALER_BASE, 6'(beam));
    req_wdat = '0;
    case (state)
      S_WR_THRESH: begin
        req_we   = 1'b1;
        req_adr  = beam_addr(THRESH_BASE, 6'(beam));
        req_wdat = 32'(shadow[beam]);
      end
      S_RB_THRESH: req_adr = beam_addr(THRESH_BASE, 6'(beam));
      S_WR_APPLY: begin
        req_we   = 1'b1;
        req_adr  = APPLY_ADDR;
        req_wdat = APPLY_WORD;
      end
      default: ;
    endcase
  end

  // wb_rdat still holds the scaler just read while in CALC.
  always_comb begin
    cur       = shadow[beam];
    cnt_ext   = {1'b0, wb_rdat};
    hi        = {1'b0, target_i} + {17'd0, deadband_i};
    lo        = ({16'd0, deadband_i} > target_i) ? 33'd0 : ({1'b0, target_i} - {17'd0, deadband_i});
    up_sum    = {1'b0, cur} + TB1'(step_i);
    dn_limit  = {1'b0, THRESH_MIN} + TB1'(step_i);
    calc_next = cur;
    if (cnt_ext > hi)
      calc_next = (up_sum > {1'b0, THRESH_MAX}) ? THRESH_MAX : up_sum[THRESH_BITS-1:0];
    else if (cnt_ext < lo)
      calc_next = ({1'b0, cur} < dn_limit) ? THRESH_MIN : cur - THRESH_BITS'(step_i);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state   <= S_IDLE;
      beam    <= '0;
      pending <= 1'b0;
      err_r   <= 2'b00;
      req     <= 1'b0;
      for (int i = 0; i < NSLOT; i++) shadow[i] <= THRESH_INIT;
    end else begin
      req <= 1'b0;
      // Single-deep request latch; a further period while one is queued is lost.
      if (state != S_IDLE && count_done_i && enable_i) begin
        if (pending) err_r[1] <= 1'b1;
        else         pending  <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if ((count_done_i || pending) && enable_i) begin
            beam    <= '0;
            pending <= 1'b0;
            state   <= S_RD_SCALER;
            req     <= 1'b1;
          end
        end
        S_RD_SCALER: begin
          if (wb_err) begin
            err_r[0] <= 1'b1;
            state    <= S_IDLE;
          end else if (wb_done) begin
            if (!enable_i) begin
              state   <= S_IDLE;
              pending <= 1'b0;
            end else begin
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (!enable_i) begin
            state   <= S_IDLE;
            pending <= 1'b0;
          end else begin
            shadow[beam] <= calc_next;
            state        <= S_WR_THRESH;
            req          <= 1'b1;
          end
        end
        S_WR_THRESH: begin
          if (wb_err) begin
            err_r[0] <= 1'b1;
            state    <= S_IDLE;
          end else if (wb_done) begin
            if (!enable_i) begin
              state   <= S_IDLE;
              pending <= 1'b0;
            end else begin
`ifdef THRESH_SERVO_READBACK_EN
              state <= S_RB_THRESH;
`else
              if (beam == LAST_BEAM) begin
                state <= S_WR_APPLY;
              end else begin
                beam  <= beam + 1'b1;
                state <= S_RD_SCALER;
              end
`endif
              req <= 1'b1;
            end
          end
        end
`ifdef THRESH_SERVO_READBACK_EN
        S_RB_THRESH: begin
          if (wb_err || (wb_done && wb_rdat[THRESH_BITS-1:0] != shadow[beam])) begin
            err_r[0] <= 1'b1;
            state    <= S_IDLE;
          end else if (wb_done) begin
            if (!enable_i) begin
              state   <= S_IDLE;
              pending <= 1'b0;
            end else begin
              if (beam == LAST_BEAM) begin
                state <= S_WR_APPLY;
              end else begin
                beam  <= beam + 1'b1;
                state <= S_RD_SCALER;
              end
              req <= 1'b1;
            end
          end
        end
`endif
        S_WR_APPLY: begin
          if (wb_err) begin
            err_r[0] <= 1'b1;
            state    <= S_IDLE;
          end else if (wb_done) begin
            if (!enable_i) begin
              state   <= S_IDLE;
              pending <= 1'b0;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  l1_servo_wbm #(
    .WB_TIMEOUT (WB_TIMEOUT)
  ) u_wbm (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .req       (req),
    .we        (req_we),
    .adr       (req_adr),
    .wdat      (req_wdat),
    .done      (wb_done),
    .err       (wb_err),
    .rdat      (wb_rdat),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_ack_i (wbm_ack_i),
    .wbm_err_i (wbm_err_i),
    .wbm_rty_i (wbm_rty_i)
  );

endmodule

// File: tb/tb_l1_threshold_servo.sv
// tb/tb_l1_threshold_servo.sv - scoreboard bench for l1_threshold_servo with a Wishbone slave model
// Readback scenario compiled in when THRESH_SERVO_READBACK_EN is defined.
module tb_l1_threshold_servo;

  localparam int T_MAX  = 'h3FFFF;
  localparam int T_MIN  = 1000;
  localparam int T_INIT = 4000;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        count_done;
  logic [31:0] target;
  logic [15:0] deadband;
  logic [7:0]  step;
  logic        wbm_cyc, wbm_stb, wbm_we;
  logic [14:0] wbm_adr;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel;
  logic [31:0] wbm_rdat = 32'd0;
  logic        wbm_ack = 1'b0;
  logic        wbm_err = 1'b0;
  logic        wbm_rty = 1'b0;
  logic        busy_o, done_o;
  logic [1:0]  err_o;

  always #5 clk = ~clk;

  l1_threshold_servo dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .enable_i     (enable),
    .count_done_i (count_done),
    .target_i     (target),
    .deadband_i   (deadband),
    .step_i       (step),
    .wbm_cyc_o    (wbm_cyc),
    .wbm_stb_o    (wbm_stb),
    .wbm_we_o     (wbm_we),
    .wbm_adr_o    (wbm_adr),
    .wbm_dat_o    (wbm_dat_o),
    .wbm_sel_o    (wbm_sel),
    .wbm_dat_i    (wbm_rdat),
    .wbm_ack_i    (wbm_ack),
    .wbm_err_i    (wbm_err),
    .wbm_rty_i    (wbm_rty),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected bus transfers: {12'b0, we, sel, adr, wdata-or-0}
  logic [63:0] exp_q[$];
  int          m_shadow[2];
  logic [31:0] scaler[2];
  logic [31:0] thr[2];
  logic [14:0] hold_adr;
  logic        rb_zero;
  bit          in_xfer = 0;
  int          xfer_len = 0, last_len = 0, n_xfer = 0, done_cnt = 0, busy_viol = 0, s_idx;

  function automatic int calc(input int sh, input longint cnt, input longint tgt, input longint db, input int st);
    longint hi, lo;
    int n;
    hi = tgt + db;
    lo = (db > tgt) ? 0 : tgt - db;
    n = sh;
    if (cnt > hi) begin
      n = sh + st;
      if (n > T_MAX) n = T_MAX;
    end else if (cnt < lo) begin
      n = sh - st;
      if (n < T_MIN) n = T_MIN;
    end
    return n;
  endfunction

  task automatic push_x(input logic we, input logic [14:0] adr, input logic [31:0] dat);
    exp_q.push_back({12'd0, we, 4'hF, adr, dat});
  endtask

  task automatic expect_beam(input int b);
    push_x(1'b0, 15'h0400 + 15'(4 * b), 32'd0);
    m_shadow[b] = calc(m_shadow[b], scaler[b], target, deadband, step);
    push_x(1'b1, 15'h0800 + 15'(4 * b), 32'(m_shadow[b]));
`ifdef THRESH_SERVO_READBACK_EN
    push_x(1'b0, 15'h0800 + 15'(4 * b), 32'd0);
`endif
  endtask

  task automatic expect_sweep();
    for (int b = 0; b < 2; b++) expect_beam(b);
    push_x(1'b1, 15'h0000, 32'h1);
  endtask

  // Slave model: acks on the first cycle it sees a transfer, unless the address is held off.
  always @(negedge clk) begin
    if (done_o) done_cnt++;
    if (wbm_cyc && !busy_o) busy_viol++;
    if (rst || !(wbm_cyc && wbm_stb)) begin
      if (in_xfer) last_len = xfer_len;
      in_xfer = 0;
      wbm_ack = 1'b0;
    end else if (!in_xfer) begin
      in_xfer = 1;
      xfer_len = 1;
      n_xfer++;
      check("xfer_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0)
        check("xfer", {12'd0, wbm_we, wbm_sel, wbm_adr, wbm_we ? wbm_dat_o : 32'd0}, exp_q.pop_front());
      if (wbm_adr != hold_adr) begin
        wbm_ack  = 1'b1;
        wbm_rdat = 32'd0;
        s_idx    = int'(wbm_adr[2]);
        if (wbm_adr >= 15'h0800 && wbm_adr < 15'h0808) begin
          if (wbm_we) thr[s_idx] = wbm_dat_o;
          else        wbm_rdat = rb_zero ? 32'd0 : thr[s_idx];
        end else if (wbm_adr >= 15'h0400 && wbm_adr < 15'h0408) begin
          wbm_rdat = scaler[s_idx];
        end
      end
    end else begin
      xfer_len++;
      wbm_ack = 1'b0;
    end
  end

  task automatic pulse();
    @(negedge clk) count_done = 1'b1;
    @(negedge clk) count_done = 1'b0;
  endtask

  task automatic wait_done(input int n, input string tag);
    int k = 0;
    while (done_cnt < n && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check(tag, 64'(done_cnt >= n), 64'd1);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    @(negedge clk);
    while (busy_o && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check(tag, 64'(busy_o), 64'd0);
  endtask

  task automatic wait_cyc(input string tag);
    int k = 0;
    while (!wbm_cyc && k < 100) begin
      @(negedge clk);
      k++;
    end
    check(tag, 64'(wbm_cyc), 64'd1);
  endtask

  task automatic run_sweep(input string tag);
    int d0;
    d0 = done_cnt;
    expect_sweep();
    pulse();
    wait_done(d0 + 1, {tag, "_done"});
    wait_idle({tag, "_idle"});
    check({tag, "_done1"}, 64'(done_cnt - d0), 64'd1);
    check({tag, "_sb"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    enable = 1'b0;
    count_done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_shadow[0] = T_INIT;
    m_shadow[1] = T_INIT;
    exp_q.delete();
  endtask

  initial begin
    int d0, n0, diff;
    rst = 1'b1; enable = 1'b0; count_done = 1'b0;
    target = 32'd1000; deadband = 16'd50; step = 8'd10;
    hold_adr = 15'h7FFF; rb_zero = 1'b0;
    scaler[0] = 32'd2000; scaler[1] = 32'd10;
    thr[0] = 32'd0; thr[1] = 32'd0;
    m_shadow[0] = T_INIT; m_shadow[1] = T_INIT;
    repeat (3) @(negedge clk);
    check("reset_outs", 64'({wbm_cyc, wbm_stb, wbm_we, wbm_adr, wbm_dat_o, wbm_sel, busy_o, done_o, err_o}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", 64'(busy_o), 64'd0);
    enable = 1'b1;

    // Basic sweep: beam 0 above window steps up, beam 1 below steps down.
    run_sweep("basic");
    check("basic_thr0", 64'(thr[0]), 64'd4010);
    check("basic_thr1", 64'(thr[1]), 64'd3990);

    // Ramp beam 0 to THRESH_MAX-3 (beam 1 saturates at THRESH_MIN on the way).
    step = 8'd255;
    while (m_shadow[0] + 255 <= T_MAX - 3) run_sweep("ramp");
    diff = T_MAX - 3 - m_shadow[0];
    if (diff > 0) begin
      step = 8'(diff);
      run_sweep("ramp_fin");
    end
    check("ramp_thr0", 64'(thr[0]), 64'(T_MAX - 3));
    step = 8'd10;
    run_sweep("sat");
    check("sat_thr0_max", 64'(thr[0]), 64'h3FFFF);
    check("sat_thr1_min", 64'(thr[1]), 64'd1000);
    scaler[0] = 32'd1025;
    run_sweep("window");
    check("window_thr0", 64'(thr[0]), 64'h3FFFF);

    // Timeout on scaler 1.
    do_reset();
    enable = 1'b1;
    scaler[0] = 32'd2000;
    check("err_clear", 64'(err_o), 64'd0);
    hold_adr = 15'h0404;
    expect_beam(0);
    push_x(1'b0, 15'h0404, 32'd0);
    d0 = done_cnt;
    pulse();
    wait_idle("tmo_idle");
    check("tmo_len", 64'(last_len), 64'd255);
    check("tmo_err", 64'(err_o), 64'd1);
    check("tmo_sb", 64'(exp_q.size()), 64'd0);
    check("tmo_nodone", 64'(done_cnt - d0), 64'd0);
    hold_adr = 15'h7FFF;
    n0 = n_xfer;
    repeat (20) @(negedge clk);
    check("tmo_quiet", 64'(n_xfer), 64'(n0));
    run_sweep("after_err");
    check("err_sticky", 64'(err_o), 64'd1);

    // Overrun: three periods during one sweep.
    do_reset();
    enable = 1'b1;
    d0 = done_cnt;
    expect_sweep();
    expect_sweep();
    pulse();
    repeat (3) @(negedge clk);
    pulse();
    repeat (3) @(negedge clk);
    pulse();
    wait_done(d0 + 2, "ovr_done");
    wait_idle("ovr_idle");
    check("ovr_cnt", 64'(done_cnt - d0), 64'd2);
    check("ovr_err", 64'(err_o), 64'd2);
    check("ovr_sb", 64'(exp_q.size()), 64'd0);
    repeat (30) @(negedge clk);
    check("ovr_no_third", 64'(done_cnt - d0), 64'd2);

    // Disable during the first scaler read.
    do_reset();
    enable = 1'b1;
    d0 = done_cnt;
    n0 = n_xfer;
    push_x(1'b0, 15'h0400, 32'd0);
    pulse();
    wait_cyc("dis_cyc");
    enable = 1'b0;
    wait_idle("dis_idle");
    repeat (20) @(negedge clk);
    check("dis_sb", 64'(exp_q.size()), 64'd0);
    check("dis_xfers", 64'(n_xfer), 64'(n0 + 1));
    check("dis_nodone", 64'(done_cnt - d0), 64'd0);
    pulse();
    repeat (3) @(negedge clk);
    enable = 1'b1;
    repeat (20) @(negedge clk);
    check("dis_ignored", 64'(n_xfer), 64'(n0 + 1));
    check("dis_busy", 64'(busy_o), 64'd0);

`ifdef THRESH_SERVO_READBACK_EN
    // Readback mismatch aborts before the apply write.
    do_reset();
    enable = 1'b1;
    rb_zero = 1'b1;
    d0 = done_cnt;
    expect_beam(0);
    pulse();
    wait_idle("rb_idle");
    check("rb_err", 64'(err_o), 64'd1);
    check("rb_sb", 64'(exp_q.size()), 64'd0);
    check("rb_nodone", 64'(done_cnt - d0), 64'd0);
    rb_zero = 1'b0;
`endif

    // Reset mid-transfer drops cyc/stb without waiting for a clock edge.
    do_reset();
    enable = 1'b1;
    hold_adr = 15'h0400;
    push_x(1'b0, 15'h0400, 32'd0);
    pulse();
    wait_cyc("arst_cyc");
    #2 rst = 1'b1;
    #1 check("arst_drop", 64'({wbm_cyc, wbm_stb, busy_o}), 64'd0);
    hold_adr = 15'h7FFF;
    do_reset();

    check("busy_during_xfer", 64'(busy_viol), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
